floor_request_encoder: RTL and testbench



---
 rtl/floor_request_encoder_pkg.sv | 16 +
 rtl/floor_request_encoder_btn_debounce.sv | 52 +++++
 rtl/floor_request_encoder.sv | 110 +++++++++++
 tb/tb_floor_request_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/floor_request_encoder_pkg.sv
// Shared constants and types for the floor-call encoding path.
package floor_request_encoder_pkg;

  // Floor codes are 3 bits wide, matching the floor display decoder.
  localparam int CODE_W = 3;

  // Default number of call buttons on the board.
  localparam int DEFAULT_NUM_FLOORS = 4;

  // Output handshake FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/floor_request_encoder_btn_debounce.sv
// One push button: two-flop synchroniser, stability-counter debounce and
// a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] cnt;
  logic            settle;

  assign settle = (cnt == DB_W'(DB_CYCLES - 1));

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has disagreed with the current one long enough; flag presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (settle) begin
        cnt   <= '0;
        level <= sync_b;
        rise  <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/floor_request_encoder.sv
// Turns debounced floor-call buttons into latched pending calls and offers
// them one at a time, round-robin, as 3-bit floor codes over valid/ack.
module floor_request_encoder
  import floor_request_encoder_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int DB_CYCLES  = 50000,
  parameter int DB_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  req_ack,
  output logic                  req_valid,
  output logic [CODE_W-1:0]     req_code,
  output logic [NUM_FLOORS-1:0] pending
);

  // Debounced levels are not needed here; the press pulses carry the calls.
  logic [NUM_FLOORS-1:0] unused_levels;
  logic [NUM_FLOORS-1:0] set;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [CODE_W-1:0]     ptr;
  logic [CODE_W-1:0]     sel_code;
  logic                  sel_found;
  logic                  ack_taken;
  state_t                state;

  for (genvar k = 0; k < NUM_FLOORS; k++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn[k]),
      .level(unused_levels[k]),
      .rise (set[k])
    );
  end

  assign ack_taken = (state == ST_OFFER) && req_ack;

  // One-hot mask of the floor whose offer is being acknowledged this cycle.
  always_comb begin
    clear_mask = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      clear_mask[k] = ack_taken && (req_code == CODE_W'(k));
    end
  end

  // Round-robin pick: first pending call at or above ptr, wrapping around.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_code  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_FLOORS) begin
        idx = idx - NUM_FLOORS;
      end
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_code  = CODE_W'(idx);
      end
    end
  end

  // Latch presses; an ack of the same floor wins so a repeat press while served is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | set) & ~clear_mask;
    end
  end

  // Offer one call at a time and hold the code steady until it is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_code  <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            req_code  <= sel_code;
            req_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (req_ack) begin
            req_valid <= 1'b0;
            ptr       <= (req_code == CODE_W'(NUM_FLOORS - 1)) ? '0 : req_code + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed bench for floor_request_encoder with a short debounce window.
module tb_floor_request_encoder;
  import floor_request_encoder_pkg::*;

  localparam int NF  = 4;
  localparam int DBC = 4;
  localparam int DBW = 3;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] btn;
  logic          req_ack;
  logic          req_valid;
  logic [2:0]    req_code;
  logic [NF-1:0] pending;

  int check_count = 0;
  int pass_count  = 0;

  floor_request_encoder #(
    .NUM_FLOORS(NF),
    .DB_CYCLES (DBC),
    .DB_W      (DBW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .req_ack  (req_ack),
    .req_valid(req_valid),
    .req_code (req_code),
    .pending  (pending)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for an offer, then check its code.
  task automatic expect_offer(input string tag, input logic [2:0] code);
    int n = 0;
    while (req_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(req_valid), 32'd1);
    check({tag, "_code"}, 32'(req_code), 32'(code));
  endtask

  // Acknowledge for one cycle; the offer must drop on the next cycle.
  task automatic do_ack(input string tag);
    req_ack = 1'b1;
    step(1);
    req_ack = 1'b0;
    check({tag, "_ack_drop"}, 32'(req_valid), 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n   = 1'b0;
    btn     = '0;
    req_ack = 1'b0;

    // Reset held while buttons toggle
    step(1);
    btn = 4'b1111;
    step(3);
    btn = 4'b0101;
    step(3);
    check("rst_valid", 32'(req_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_code", 32'(req_code), 32'd0);
    btn = '0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Single clean press: offer appears exactly 8 edges after the press
    btn = 4'b0100;
    step(7);
    check("lat_early_valid", 32'(req_valid), 32'd0);
    check("lat_pending", 32'(pending), 32'b0100);
    step(1);
    check("lat_valid", 32'(req_valid), 32'd1);
    check("lat_code", 32'(req_code), 32'd2);
    do_ack("single");
    check("single_pending_clr", 32'(pending), 32'd0);
    btn = '0;
    step(10);

    // Bounce on floor 1 must not register
    btn = 4'b0010; step(3);
    btn = 4'b0000; step(2);
    btn = 4'b0010; step(3);
    btn = 4'b0000; step(10);
    check("bounce_pending", 32'(pending), 32'd0);
    check("bounce_valid", 32'(req_valid), 32'd0);
    btn = 4'b0010;
    step(8);
    check("stable_pending", 32'(pending), 32'b0010);
    expect_offer("stable", 3'd1);
    do_ack("stable");
    btn = '0;
    step(10);

    // Reset in the middle of an offer clears everything asynchronously
    btn = 4'b1000;
    expect_offer("pre_rst", 3'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(req_valid), 32'd0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_code", 32'(req_code), 32'd0);
    btn = '0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Simultaneous presses served round-robin from floor 0
    btn = 4'b1011;
    step(8);
    check("sim_pending", 32'(pending), 32'b1011);
    expect_offer("sim0", 3'd0);
    do_ack("sim0");
    expect_offer("sim1", 3'd1);
    do_ack("sim1");
    expect_offer("sim3", 3'd3);
    do_ack("sim3");
    check("sim_pending_done", 32'(pending), 32'd0);
    btn = '0;
    step(10);
    btn = 4'b0001;
    expect_offer("wrap0", 3'd0);
    do_ack("wrap0");
    btn = '0;
    step(10);

    // A newer call does not disturb the code on offer
    btn = 4'b0010;
    expect_offer("hold1", 3'd1);
    btn = 4'b1010;
    step(20);
    check("hold_valid", 32'(req_valid), 32'd1);
    check("hold_code", 32'(req_code), 32'd1);
    check("hold_pending", 32'(pending), 32'b1010);
    do_ack("hold1");
    expect_offer("hold3", 3'd3);
    do_ack("hold3");
    btn = '0;
    step(10);

    // Repeat press of the floor being served lands on the ack cycle
    btn = 4'b0100;
    expect_offer("coll", 3'd2);
    btn = '0;
    step(10);
    check("coll_still_offered", 32'(req_code), 32'd2);
    btn = 4'b0100;
    step(6);
    req_ack = 1'b1;
    step(1);
    req_ack = 1'b0;
    check("coll_ack_drop", 32'(req_valid), 32'd0);
    check("coll_pending", 32'(pending), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | req_valid;
    end
    check("coll_no_reoffer", 32'(seen), 32'd0);
    check("coll_pending_end", 32'(pending), 32'd0);
    btn = '0;
    step(4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
